sdram_rq_rnd: RTL and testbench

- Per-slot SDRAM request front-end with an embedded pseudo-random generator.
- Turns a game-side address/valid pair into a one-shot SDRAM request (read or write) and offsets the address.
- Captures the returned data word and holds a data-ready level until the next access.
- A free-running 16-bit LFSR supplies random values for test or jitter logic in the same client.

---
 rtl/sdram_rq_rnd_pkg.sv | 12 +
 rtl/sdram_rq_rnd_lfsr16.sv | 20 ++
 rtl/sdram_rq_rnd.sv | 101 ++++++++++
 tb/tb_sdram_rq_rnd.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_rq_rnd_pkg.sv
// Shared constants for the SDRAM request slot with embedded LFSR.
package sdram_rq_rnd_pkg;

    localparam int unsigned SDRAM_AW   = 22;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    // One Fibonacci step of x^16+x^15+x^13+x^4+1
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[14] ^ cur[12] ^ cur[3]};
    endfunction

endpackage

// File: rtl/sdram_rq_rnd_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, advances only when adv is high.
module lfsr16
    import sdram_rq_rnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] lfsr
);

    // Shift register: load seed on reset, step on adv, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (adv) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

endmodule

// File: rtl/sdram_rq_rnd.sv
// Per-slot SDRAM request front-end: turns addr/addr_ok into a one-shot
// request, captures returned data and provides a pseudo-random source.
module sdram_rq_rnd
    import sdram_rq_rnd_pkg::*;
#(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       addr,
    input  logic [21:0]         offset,
    input  logic                addr_ok,
    input  logic                wrin,
    input  logic [31:0]         din,
    input  logic                din_ok,
    input  logic                we,
    input  logic                adv,
    output logic                req,
    output logic                req_rnw,
    output logic                data_ok,
    output logic [21:0]         sdram_addr,
    output logic [DW-1:0]       wrdata,
    output logic [DW-1:0]       dout,
    output logic [15:0]         lfsr
);

    logic                last_ok;
    logic [AW-1:0]       last_addr;
    logic                start;
    logic [SDRAM_AW-1:0] addr_ext;
    logic [DW-1:0]       din_slice;
    logic                unused_bits;

    // Zero-extend the client address and add the slot base (wraps at 2^22)
    always_comb begin
        addr_ext = '0;
        addr_ext[AW-1:0] = addr;
        sdram_addr = addr_ext + offset;
    end

    // A new access begins on addr_ok rising or on an address change while valid
    always_comb begin
        start = addr_ok && (!last_ok || (addr != last_addr));
    end

    // Pick the part of the SDRAM bus the client cares about
    generate
        if (DW == 32) begin : g_dw32
            always_comb din_slice = din;
        end else if (DW == 16) begin : g_dw16
            always_comb din_slice = din[15:0];
        end else begin : g_dw8
            always_comb din_slice = addr[0] ? din[15:8] : din[7:0];
        end
    endgenerate

    // Not every bus bit is consumed for every DW setting
    assign unused_bits = ^{din, addr};

    assign wrdata = dout;

    // Request/data handshake; later assignments deliberately override earlier ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req       <= 1'b0;
            req_rnw   <= 1'b1;
            data_ok   <= 1'b0;
            dout      <= '0;
            last_ok   <= 1'b0;
            last_addr <= '0;
        end else begin
            last_ok   <= addr_ok;
            last_addr <= addr;
            if (we) begin
                req <= 1'b0;
                if (din_ok) begin
                    data_ok <= 1'b1;
                    dout    <= din_slice;
                end
            end
            if (!addr_ok) begin
                req     <= 1'b0;
                data_ok <= 1'b0;
            end
            if (start) begin
                req     <= 1'b1;
                req_rnw <= ~wrin;
                data_ok <= 1'b0;
            end
        end
    end

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .lfsr  (lfsr)
    );

endmodule

// File: tb/tb_sdram_rq_rnd.sv
// Self-checking bench for sdram_rq_rnd (DW=16 main instance, DW=8 companion).
module tb_sdram_rq_rnd;

    logic        clk;
    logic        rst_n;
    logic [21:0] addr;
    logic [21:0] offset;
    logic        addr_ok;
    logic        wrin;
    logic [31:0] din;
    logic        din_ok;
    logic        we;
    logic        adv;

    logic        req, req_rnw, data_ok;
    logic [21:0] sdram_addr;
    logic [15:0] wrdata, dout, lfsr;

    logic        req8, req_rnw8, data_ok8;
    logic [21:0] sdram_addr8;
    logic [7:0]  wrdata8, dout8;
    logic [15:0] lfsr8;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb16[$];
    logic [7:0]  sb8[$];

    sdram_rq_rnd #(.AW(22), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .offset(offset),
        .addr_ok(addr_ok), .wrin(wrin), .din(din), .din_ok(din_ok),
        .we(we), .adv(adv), .req(req), .req_rnw(req_rnw),
        .data_ok(data_ok), .sdram_addr(sdram_addr), .wrdata(wrdata),
        .dout(dout), .lfsr(lfsr)
    );

    sdram_rq_rnd #(.AW(22), .DW(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .offset(offset),
        .addr_ok(addr_ok), .wrin(wrin), .din(din), .din_ok(din_ok),
        .we(we), .adv(adv), .req(req8), .req_rnw(req_rnw8),
        .data_ok(data_ok8), .sdram_addr(sdram_addr8), .wrdata(wrdata8),
        .dout(dout8), .lfsr(lfsr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        addr_ok = 1'b0; we = 1'b0; din_ok = 1'b0; wrin = 1'b0; adv = 1'b0;
        din = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] exp_rst;
        exp_rst = 16'hACE1;
        do_reset();
        // Create non-reset state, then assert reset between edges
        addr = 22'h3; offset = '0; addr_ok = 1'b1; wrin = 1'b1; adv = 1'b1;
        tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (req !== 1'b0 || req_rnw !== 1'b1 || data_ok !== 1'b0 || lfsr !== exp_rst) begin
            errors++;
            $display("FAIL reset_async: req=%b rnw=%b data_ok=%b lfsr=%h, want 0 1 0 %h",
                     req, req_rnw, data_ok, lfsr, exp_rst);
        end
        checks++;
        if (dout !== 16'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 0000", dout);
        end
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        logic [15:0] exp;
        addr = 22'h000010; offset = 22'h100000; wrin = 1'b0; addr_ok = 1'b1;
        #1;
        checks++;
        if (sdram_addr !== 22'h100010) begin
            errors++;
            $display("FAIL read_addr: got %h want 100010", sdram_addr);
        end
        tick();
        checks++;
        if (req !== 1'b1 || req_rnw !== 1'b1) begin
            errors++;
            $display("FAIL read_req: req=%b rnw=%b want 1 1", req, req_rnw);
        end
        we = 1'b1;
        tick();
        checks++;
        if (req !== 1'b0 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL read_ack: req=%b data_ok=%b want 0 0", req, data_ok);
        end
        din = 32'h1234ABCD; din_ok = 1'b1;
        sb16.push_back(16'hABCD);
        tick();
        din_ok = 1'b0; we = 1'b0; din = '0;
        checks++;
        if (data_ok !== 1'b1) begin
            errors++;
            $display("FAIL read_data_ok: got %b want 1", data_ok);
        end else begin
            exp = sb16.pop_front();
            checks++;
            if (dout !== exp || wrdata !== exp) begin
                errors++;
                $display("FAIL read_dout: dout=%h wrdata=%h want %h", dout, wrdata, exp);
            end
        end
        repeat (3) tick();
        checks++;
        if (data_ok !== 1'b1 || req !== 1'b0) begin
            errors++;
            $display("FAIL read_hold: data_ok=%b req=%b want 1 0", data_ok, req);
        end
        addr_ok = 1'b0;
        tick();
        checks++;
        if (data_ok !== 1'b0) begin
            errors++;
            $display("FAIL read_drop: data_ok=%b want 0", data_ok);
        end
    endtask

    task automatic test_write();
        logic [15:0] exp;
        int budget;
        addr = 22'h20; offset = '0; wrin = 1'b1; addr_ok = 1'b1;
        tick();
        wrin = 1'b0;
        checks++;
        if (req !== 1'b1 || req_rnw !== 1'b0) begin
            errors++;
            $display("FAIL write_req: req=%b rnw=%b want 1 0", req, req_rnw);
        end
        we = 1'b1; din = 32'hFFFF5555; din_ok = 1'b1;
        sb16.push_back(16'h5555);
        tick();
        we = 1'b0; din_ok = 1'b0;
        budget = 0;
        while (data_ok !== 1'b1 && budget < 8) begin
            tick();
            budget++;
        end
        checks++;
        if (data_ok !== 1'b1 || budget != 0) begin
            errors++;
            $display("FAIL write_done: data_ok=%b after %0d extra cycles, want 1 after 0",
                     data_ok, budget);
        end else begin
            exp = sb16.pop_front();
            checks++;
            if (dout !== exp) begin
                errors++;
                $display("FAIL write_dout: got %h want %h", dout, exp);
            end
        end
        addr_ok = 1'b0;
        tick();
    endtask

    task automatic test_addr_change();
        logic [15:0] exp;
        addr = 22'h5; addr_ok = 1'b1;
        tick();
        we = 1'b1; din = 32'h00000077; din_ok = 1'b1;
        sb16.push_back(16'h0077);
        tick();
        we = 1'b0; din_ok = 1'b0;
        exp = sb16.pop_front();
        checks++;
        if (data_ok !== 1'b1 || dout !== exp) begin
            errors++;
            $display("FAIL chg_first: data_ok=%b dout=%h want 1 %h", data_ok, dout, exp);
        end
        addr = 22'h6;
        tick();
        checks++;
        if (req !== 1'b1 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL chg_restart: req=%b data_ok=%b want 1 0", req, data_ok);
        end
        addr_ok = 1'b0;
        tick();
    endtask

    task automatic test_cancel_and_priority();
        addr = 22'h8; addr_ok = 1'b1;
        tick();
        addr_ok = 1'b0;
        tick();
        checks++;
        if (req !== 1'b0) begin
            errors++;
            $display("FAIL cancel_req: got %b want 0", req);
        end
        we = 1'b1; din_ok = 1'b1; din = 32'h1111;
        tick();
        we = 1'b0; din_ok = 1'b0;
        checks++;
        if (data_ok !== 1'b0) begin
            errors++;
            $display("FAIL late_din_ok: data_ok=%b want 0", data_ok);
        end
        // Start coinciding with we/din_ok must win
        addr = 22'h9; addr_ok = 1'b1; we = 1'b1; din_ok = 1'b1;
        tick();
        we = 1'b0; din_ok = 1'b0;
        checks++;
        if (req !== 1'b1 || data_ok !== 1'b0) begin
            errors++;
            $display("FAIL start_wins: req=%b data_ok=%b want 1 0", req, data_ok);
        end
        // No timeout: req holds while never acked
        repeat (20) tick();
        checks++;
        if (req !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: req=%b want 1", req);
        end
        addr_ok = 1'b0;
        tick();
    endtask

    task automatic test_wrap_dw8();
        logic [7:0] exp;
        addr = 22'h3FFFFF; offset = 22'h2;
        #1;
        checks++;
        if (sdram_addr !== 22'h000001) begin
            errors++;
            $display("FAIL wrap: got %h want 000001", sdram_addr);
        end
        offset = '0;
        for (int k = 0; k < 2; k++) begin
            addr = (k == 0) ? 22'h3 : 22'h4;
            addr_ok = 1'b1;
            tick();
            we = 1'b1; din_ok = 1'b1; din = 32'h0000BEEF;
            sb8.push_back((k == 0) ? 8'hBE : 8'hEF);
            tick();
            we = 1'b0; din_ok = 1'b0;
            exp = sb8.pop_front();
            checks++;
            if (data_ok8 !== 1'b1 || dout8 !== exp) begin
                errors++;
                $display("FAIL dw8_slice%0d: data_ok=%b dout=%h want 1 %h", k, data_ok8, dout8, exp);
            end
            addr_ok = 1'b0;
            tick();
        end
    endtask

    task automatic test_lfsr();
        logic [15:0] model;
        logic [15:0] exp;
        int zeros;
        int early;
        do_reset();
        model = 16'hACE1;
        adv = 1'b1;
        model = model_step(model);
        sb16.push_back(model);
        tick();
        adv = 1'b0;
        exp = sb16.pop_front();
        checks++;
        if (lfsr !== exp || exp !== 16'h59C3) begin
            errors++;
            $display("FAIL lfsr_step1: got %h want 59c3", lfsr);
        end
        repeat (10) tick();
        checks++;
        if (lfsr !== 16'h59C3) begin
            errors++;
            $display("FAIL lfsr_hold: got %h want 59c3", lfsr);
        end
        // A few further steps against the reference polynomial
        for (int s = 0; s < 8; s++) begin
            adv = 1'b1;
            model = model_step(model);
            sb16.push_back(model);
            tick();
            exp = sb16.pop_front();
            checks++;
            if (lfsr !== exp) begin
                errors++;
                $display("FAIL lfsr_seq%0d: got %h want %h", s, lfsr, exp);
            end
        end
        adv = 1'b0;
        do_reset();
        zeros = 0;
        early = 0;
        adv = 1'b1;
        for (int n = 1; n <= 65535; n++) begin
            tick();
            if (lfsr == 16'h0) zeros++;
            if (n < 65535 && lfsr == 16'hACE1) early++;
        end
        adv = 1'b0;
        checks++;
        if (lfsr !== 16'hACE1) begin
            errors++;
            $display("FAIL lfsr_period: got %h want ace1", lfsr);
        end
        checks++;
        if (zeros != 0 || early != 0) begin
            errors++;
            $display("FAIL lfsr_cycle: zero hits %0d early returns %0d, want 0 0", zeros, early);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        addr = '0;
        offset = '0;
        idle_inputs();
        test_reset();
        test_read();
        test_write();
        test_addr_change();
        test_cancel_and_priority();
        test_wrap_dw8();
        test_lfsr();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
